uart_port_scheduler: RTL and testbench

//   Bus-master sequencer for the UART port block. It owns the port's data_m_* slave

---
 rtl/uart_port_scheduler.sv | 98 +++++++++
 tb/tb_uart_port_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_scheduler.sv
// uart_port_scheduler: polls the UART status byte, delivers rx bytes, round-robins two tx requesters
// Ports: tx0_*/tx1_* byte requesters (ready = 1-cycle accept pulse); rx_* holding register to the
// consumer; uart_* single-cycle strobed accesses to the port slave, completed by uart_ack.
module uart_port_scheduler #(
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx0_valid,
  input  logic [7:0]  tx0_data,
  output logic        tx0_ready,
  input  logic        tx1_valid,
  input  logic [7:0]  tx1_data,
  output logic        tx1_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        uart_cs,
  output logic        uart_access,
  output logic        uart_wr_en,
  output logic [1:0]  uart_bytesel,
  output logic [15:0] uart_data_wr,
  input  logic [15:0] uart_data_rd,
  input  logic        uart_ack
);
  localparam int GW = $clog2(POLL_GAP + 1);
  typedef enum logic [2:0] {IDLE, ST_REQ, ST_WAIT, DECIDE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;
  state_t state, nxt;
  logic [GW-1:0] gap;
  logic rdy, busy, rr, gnt_q, do_rd, do_wr, gnt, reload;
  logic [7:0] tx_byte;
  logic unused_rd;
  assign unused_rd = &{1'b0, uart_data_rd[15:10]};
  // registered rx_valid: a consume in this same cycle cannot enable a read here
  assign do_rd = state == DECIDE && rdy && !rx_valid;
  assign do_wr = state == DECIDE && !(rdy && !rx_valid) && !busy && (tx0_valid || tx1_valid);
  // a lone valid requester wins regardless of rr
  assign gnt = tx1_valid && (!tx0_valid || rr);
  assign reload = (state == DECIDE && !do_rd && !do_wr) ||
                  ((state == RD_WAIT || state == WR_WAIT) && uart_ack);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = gap == '0 ? ST_REQ : IDLE;
      ST_REQ:  nxt = ST_WAIT;
      ST_WAIT: nxt = uart_ack ? DECIDE : ST_WAIT;
      DECIDE:  nxt = do_rd ? RD_REQ : do_wr ? WR_REQ : IDLE;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: nxt = uart_ack ? IDLE : RD_WAIT;
      WR_REQ:  nxt = WR_WAIT;
      WR_WAIT: nxt = uart_ack ? IDLE : WR_WAIT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_access = state == ST_REQ || state == RD_REQ || state == WR_REQ;
    uart_cs = uart_access;
    uart_wr_en = state == WR_REQ;
    uart_bytesel = state == ST_REQ ? 2'b10 : (state == RD_REQ || state == WR_REQ) ? 2'b01 : 2'b00;
    uart_data_wr = state == WR_REQ ? {8'h00, tx_byte} : 16'h0000;
    tx0_ready = do_wr && !gnt;
    tx1_ready = do_wr && gnt;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gap <= GW'(POLL_GAP);
      rdy <= 1'b0;
      busy <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= 8'h00;
      tx_byte <= 8'h00;
      gnt_q <= 1'b0;
      rr <= 1'b0;
    end else begin
      if (reload) gap <= GW'(POLL_GAP);
      else if (state == IDLE && gap != '0) gap <= gap - GW'(1);
      if (state == ST_WAIT && uart_ack) begin
        rdy <= uart_data_rd[8];
        busy <= uart_data_rd[9];
      end
      if (state == RD_WAIT && uart_ack) begin
        rx_valid <= 1'b1;
        rx_data <= uart_data_rd[7:0];
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (do_wr) begin
        tx_byte <= gnt ? tx1_data : tx0_data;
        gnt_q <= gnt;
      end
      if (state == WR_WAIT && uart_ack) rr <= !gnt_q;
    end
endmodule

// File: tb/tb_uart_port_scheduler.sv
// tb_uart_port_scheduler: directed and random checks of the scheduler against a UART/requester model
module tb_uart_port_scheduler;
  localparam int POLL_GAP = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic tx0_valid = 1'b0, tx1_valid = 1'b0, rx_ready = 1'b0, uart_ack = 1'b0;
  logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
  logic [15:0] uart_data_rd = 16'h0000;
  logic tx0_ready, tx1_ready, rx_valid, uart_cs, uart_access, uart_wr_en;
  logic [7:0] rx_data;
  logic [1:0] uart_bytesel;
  logic [15:0] uart_data_wr;
  logic [31:0] outs;
  assign outs = {tx0_ready, tx1_ready, rx_valid, rx_data, uart_cs, uart_access, uart_wr_en,
                 uart_bytesel, uart_data_wr};

  uart_port_scheduler #(.POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
    .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .uart_cs(uart_cs), .uart_access(uart_access), .uart_wr_en(uart_wr_en),
    .uart_bytesel(uart_bytesel), .uart_data_wr(uart_data_wr),
    .uart_data_rd(uart_data_rd), .uart_ack(uart_ack)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] q0[$], q1[$], rxq[$], wlog[$], rx_in[$], rx_out[$];
  int busy_polls = 0, max_dly = 0, ack_cnt = 0, pend = 0, rx_mode = 0;
  int rd_count = 0, st_acks = 0, p0 = 0, p1 = 0, cyc_n = 0, last_st_cyc = -1, expect_next = 1;
  logic m_rxv = 1'b0, m_rr = 1'b0, m_gnt = 1'b0, m_last_rdy = 1'b0, m_last_busy = 1'b0;
  logic decide_now = 1'b0, prev_acc = 1'b0;
  logic [7:0] m_rxd = 8'h00, m_wbyte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: UART slave and requesters drive at negedge, then the outputs are judged
  task automatic cyc();
    logic st_done, rd_done, wr_done, e0, e1, g, rd, wr;
    logic [7:0] b;
    int k;
    st_done = 1'b0; rd_done = 1'b0; wr_done = 1'b0; b = 8'h00;
    @(negedge clk);
    uart_ack = 1'b0;
    uart_data_rd = 16'($urandom);
    if (ack_cnt != 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        uart_ack = 1'b1;
        if (pend == 1) begin
          m_last_busy = busy_polls != 0;
          m_last_rdy = rxq.size() != 0;
          if (busy_polls != 0) busy_polls--;
          uart_data_rd = {6'($urandom), m_last_busy, m_last_rdy, 8'($urandom)};
          st_done = 1'b1;
          st_acks++;
        end else if (pend == 2) begin
          chk("rd_has_byte", rxq.size() != 0, 1);
          if (rxq.size() != 0) b = rxq.pop_front();
          uart_data_rd = {8'($urandom), b};
          rd_done = 1'b1;
        end else if (pend == 3) wr_done = 1'b1;
        pend = 0;
      end
    end
    tx0_valid = q0.size() != 0;
    tx0_data = tx0_valid ? q0[0] : 8'($urandom);
    tx1_valid = q1.size() != 0;
    tx1_data = tx1_valid ? q1[0] : 8'($urandom);
    rx_ready = rx_mode == 2 ? 1'($urandom) : rx_mode == 1;
    #1;
    cyc_n++;
    chk("cs_eq_access", uart_cs, uart_access);
    chk("strobe_single", uart_access && prev_acc, 0);
    e0 = 1'b0; e1 = 1'b0;
    if (decide_now) begin
      rd = m_last_rdy && !m_rxv;
      wr = !rd && !m_last_busy && (tx0_valid || tx1_valid);
      g = tx1_valid && (!tx0_valid || m_rr);
      e0 = wr && !g;
      e1 = wr && g;
      expect_next = rd ? 2 : wr ? 3 : 1;
      if (wr) begin
        m_gnt = g;
        m_wbyte = g ? tx1_data : tx0_data;
      end
    end
    chk("tx0_ready", tx0_ready, e0);
    chk("tx1_ready", tx1_ready, e1);
    chk("rx_valid", rx_valid, m_rxv);
    if (m_rxv) chk("rx_data", rx_data, m_rxd);
    if (uart_access) begin
      k = uart_wr_en ? 3 : uart_bytesel == 2'b10 ? 1 : uart_bytesel == 2'b01 ? 2 : 0;
      chk("strobe_kind", k, expect_next);
      if (k == 1) begin
        if (last_st_cyc >= 0) chk("poll_gap", cyc_n - last_st_cyc > POLL_GAP, 1);
        last_st_cyc = cyc_n;
      end
      if (k == 2) rd_count++;
      if (k == 3) begin
        chk("wr_bytesel", uart_bytesel, 2'b01);
        chk("wr_data", uart_data_wr, {8'h00, m_wbyte});
        wlog.push_back(uart_data_wr[7:0]);
      end
      expect_next = 4;
      pend = k;
      ack_cnt = 1 + $urandom_range(0, max_dly);
    end
    if (tx0_ready) begin p0++; if (q0.size() != 0) void'(q0.pop_front()); end
    if (tx1_ready) begin p1++; if (q1.size() != 0) void'(q1.pop_front()); end
    if (m_rxv && rx_ready) begin rx_out.push_back(m_rxd); m_rxv = 1'b0; end
    if (rd_done) begin m_rxv = 1'b1; m_rxd = b; expect_next = 1; end
    if (wr_done) begin m_rr = !m_gnt; expect_next = 1; end
    decide_now = st_done;
    prev_acc = uart_access;
  endtask

  task automatic do_reset(input logic late_ack);
    @(negedge clk);
    reset_n = 1'b0;
    uart_ack = 1'b0;
    #1;
    chk("reset_outs", outs, 0);
    @(negedge clk);
    reset_n = 1'b1;
    uart_ack = late_ack;
    m_rxv = 1'b0; m_rr = 1'b0; expect_next = 1; decide_now = 1'b0; pend = 0; ack_cnt = 0;
    prev_acc = 1'b0; last_st_cyc = -1; busy_polls = 0;
  endtask

  initial begin
    logic [7:0] t2_exp[4];
    logic [7:0] b;
    int sa, rb, ntx;
    t2_exp = '{8'hA0, 8'hB0, 8'hA0, 8'hB0};
    do_reset(1'b0);
    q0.push_back(8'h41);
    for (int i = 0; i < 200 && wlog.size() < 1; i++) cyc();
    repeat (30) cyc();
    chk("t1_writes", wlog.size(), 1);
    chk("t1_byte", wlog[0], 8'h41);
    chk("t1_tx0_pulses", p0, 1);
    chk("t1_tx1_pulses", p1, 0);
    do_reset(1'b0);
    wlog.delete(); p0 = 0; p1 = 0;
    q0.push_back(8'hA0); q0.push_back(8'hA0);
    q1.push_back(8'hB0); q1.push_back(8'hB0);
    for (int i = 0; i < 400 && wlog.size() < 4; i++) cyc();
    chk("t2_writes", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_order", wlog[i], t2_exp[i]);
    chk("t2_tx0_pulses", p0, 2);
    chk("t2_tx1_pulses", p1, 2);
    wlog.delete(); sa = st_acks;
    busy_polls = 3;
    q1.push_back(8'hC3);
    for (int i = 0; i < 400 && wlog.size() < 1; i++) cyc();
    chk("t3_polls", st_acks - sa, 4);
    chk("t3_byte", wlog[0], 8'hC3);
    rx_mode = 0; wlog.delete(); rb = rd_count;
    rxq.push_back(8'h5A);
    sa = st_acks;
    for (int i = 0; i < 100 && st_acks == sa; i++) cyc();
    q0.push_back(8'h44);
    for (int i = 0; i < 200 && wlog.size() < 1; i++) cyc();
    chk("t4_read_first", rd_count, rb + 1);
    chk("t4_rx_valid", rx_valid, 1);
    chk("t4_rx_data", rx_data, 8'h5A);
    chk("t4_wr_byte", wlog[0], 8'h44);
    wlog.delete(); rb = rd_count;
    rxq.push_back(8'h66);
    q1.push_back(8'h77);
    for (int i = 0; i < 200 && wlog.size() < 1; i++) cyc();
    repeat (20) cyc();
    chk("t5_no_read", rd_count, rb);
    chk("t5_wr_byte", wlog[0], 8'h77);
    chk("t5_rx_hold", rx_data, 8'h5A);
    rx_mode = 1;
    cyc();
    rx_mode = 0;
    for (int i = 0; i < 100 && rd_count == rb; i++) cyc();
    repeat (5) cyc();
    chk("t5_rx_valid", rx_valid, 1);
    chk("t5_rx_data", rx_data, 8'h66);
    wlog.delete(); max_dly = 0;
    q0.push_back(8'h99);
    for (int i = 0; i < 100 && wlog.size() < 1; i++) cyc();
    do_reset(1'b1);
    repeat (60) cyc();
    chk("t6_writes", wlog.size(), 1);
    chk("t6_byte_lost", q0.size(), 0);
    do_reset(1'b0);
    wlog.delete(); rx_in.delete(); rx_out.delete(); ntx = 0;
    max_dly = 2; rx_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0 && q0.size() < 3) begin b = 8'($urandom); q0.push_back(b); ntx++; end
      if ($urandom_range(0, 9) == 0 && q1.size() < 3) begin b = 8'($urandom); q1.push_back(b); ntx++; end
      if ($urandom_range(0, 14) == 0 && rxq.size() < 3) begin
        b = 8'($urandom);
        rxq.push_back(b);
        rx_in.push_back(b);
      end
      if ($urandom_range(0, 49) == 0) busy_polls = $urandom_range(1, 3);
      cyc();
    end
    for (int i = 0; i < 3000 && (q0.size() != 0 || q1.size() != 0 || rxq.size() != 0 || m_rxv); i++) cyc();
    repeat (30) cyc();
    chk("rnd_drained", q0.size() + q1.size() + rxq.size(), 0);
    chk("rnd_writes", wlog.size(), ntx);
    chk("rnd_rx_count", rx_out.size(), rx_in.size());
    for (int i = 0; i < rx_in.size() && i < rx_out.size(); i++) chk("rnd_rx_order", rx_out[i], rx_in[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
